// File: rtl/gdma_rst_pulse_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : gdma_rst_pulse_gen                                           |
// | Description : Multi-channel host-to-GDMA reset pulse generator. Each       |
// |               channel synchronises an asynchronous host reset-request      |
// |               level, detects its rising edge and emits a registered        |
// |               reset pulse of configurable length with per-channel status.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module gdma_rst_pulse_gen #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int PULSE_LEN   = 10,
  parameter int RETRIG      = 0
) (
  input  logic              gdma_clk,
  input  logic              gdma_rst,
  input  logic [NUM_CH-1:0] host_rst_flag,
  input  logic [CNT_W-1:0]  cfg_pulse_len,
  input  logic [NUM_CH-1:0] clr_drop,
  output logic [NUM_CH-1:0] h2gdma_rst,
  output logic [NUM_CH-1:0] rst_busy,
  output logic [NUM_CH-1:0] rst_done,
  output logic [NUM_CH-1:0] req_drop
);

  localparam logic [0:0]       c_st_idle     = 1'b0;
  localparam logic [0:0]       c_st_active   = 1'b1;
  localparam logic [CNT_W-1:0] c_default_len = CNT_W'(PULSE_LEN);
  localparam logic [CNT_W-1:0] c_one         = CNT_W'(1);
  localparam bit               c_retrig      = (RETRIG != 0);

  // Counter load value shared by all channels: zero config falls back to the default length
  logic [CNT_W-1:0] len_eff;
  logic [CNT_W-1:0] len_load;

  // Resolve the effective pulse length and the value loaded into a channel counter
  always_comb begin
    len_eff  = (cfg_pulse_len == '0) ? c_default_len : cfg_pulse_len;
    len_load = len_eff - c_one;
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;
    logic [0:0]             state_q;
    logic [0:0]             state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   done_q;
    logic                   done_d;
    logic                   drop_q;
    logic                   drop_d;
    logic                   edge_det;

    // Shift the host level through the synchroniser and flag a synchronised rising edge
    always_comb begin
      sync_d   = {sync_q[SYNC_STAGES-2:0], host_rst_flag[ch]};
      prev_d   = sync_q[SYNC_STAGES-1];
      edge_det = sync_q[SYNC_STAGES-1] & ~prev_q;
    end

    // State register: synchroniser, edge delay, FSM, counter and status flops
    always_ff @(posedge gdma_clk) begin
      if (gdma_rst) begin
        sync_q  <= '0;
        prev_q  <= 1'b0;
        state_q <= c_st_idle;
        cnt_q   <= '0;
        done_q  <= 1'b0;
        drop_q  <= 1'b0;
      end else begin
        sync_q  <= sync_d;
        prev_q  <= prev_d;
        state_q <= state_d;
        cnt_q   <= cnt_d;
        done_q  <= done_d;
        drop_q  <= drop_d;
      end
    end

    // Next-state logic: start, count down, retrigger or finish the pulse
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
        c_st_idle: begin
          if (edge_det) begin
            state_d = c_st_active;
            cnt_d   = len_load;
          end
        end
        c_st_active: begin
          if (edge_det && c_retrig) begin
            cnt_d = len_load;
          end else if (cnt_q == '0) begin
            state_d = c_st_idle;
          end else begin
            cnt_d = cnt_q - c_one;
          end
        end
        default: begin
          state_d = c_st_idle;
          cnt_d   = '0;
        end
      endcase
    end

    // Output logic: completion strobe and sticky drop flag (set beats clear)
    always_comb begin
      done_d = 1'b0;
      drop_d = drop_q;
      if ((state_q == c_st_active) && (cnt_q == '0) && !(edge_det && c_retrig)) begin
        done_d = 1'b1;
      end
      if (c_retrig) begin
        drop_d = 1'b0;
      end else if ((state_q == c_st_active) && edge_det) begin
        drop_d = 1'b1;
      end else if (clr_drop[ch]) begin
        drop_d = 1'b0;
      end
    end

    assign h2gdma_rst[ch] = (state_q == c_st_active);
    assign rst_busy[ch]   = (state_q == c_st_active);
    assign rst_done[ch]   = done_q;
    assign req_drop[ch]   = drop_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_gdma_rst_pulse_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_gdma_rst_pulse_gen                                        |
// | Description : Directed self-checking bench. Instance 0 drops edges during  |
// |               a pulse, instance 1 retriggers; both share all inputs.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_gdma_rst_pulse_gen;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;

  logic              gdma_clk;
  logic              gdma_rst;
  logic [NUM_CH-1:0] host_rst_flag;
  logic [CNT_W-1:0]  cfg_pulse_len;
  logic [NUM_CH-1:0] clr_drop;
  logic [NUM_CH-1:0] h2[2];
  logic [NUM_CH-1:0] busy[2];
  logic [NUM_CH-1:0] done[2];
  logic [NUM_CH-1:0] drop[2];

  int n_checks;
  int n_errors;

  // Per-instance, per-channel observations since the last clear_obs
  int cyc;
  int hi_cnt[2][NUM_CH];
  int first_hi[2][NUM_CH];
  int rise_cnt[2][NUM_CH];
  int last_rise[2][NUM_CH];
  int done_cnt[2][NUM_CH];
  int last_done[2][NUM_CH];
  logic [NUM_CH-1:0] prv[2];

  gdma_rst_pulse_gen #(
    .NUM_CH(NUM_CH), .SYNC_STAGES(2), .CNT_W(CNT_W), .PULSE_LEN(10), .RETRIG(0)
  ) u_dut_nr (
    .gdma_clk(gdma_clk), .gdma_rst(gdma_rst), .host_rst_flag(host_rst_flag),
    .cfg_pulse_len(cfg_pulse_len), .clr_drop(clr_drop), .h2gdma_rst(h2[0]),
    .rst_busy(busy[0]), .rst_done(done[0]), .req_drop(drop[0])
  );

  gdma_rst_pulse_gen #(
    .NUM_CH(NUM_CH), .SYNC_STAGES(2), .CNT_W(CNT_W), .PULSE_LEN(10), .RETRIG(1)
  ) u_dut_rt (
    .gdma_clk(gdma_clk), .gdma_rst(gdma_rst), .host_rst_flag(host_rst_flag),
    .cfg_pulse_len(cfg_pulse_len), .clr_drop(clr_drop), .h2gdma_rst(h2[1]),
    .rst_busy(busy[1]), .rst_done(done[1]), .req_drop(drop[1])
  );

  initial gdma_clk = 1'b0;
  always #5 gdma_clk = ~gdma_clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_obs();
    cyc = 0;
    for (int d = 0; d < 2; d++) begin
      prv[d] = h2[d];
      for (int ch = 0; ch < NUM_CH; ch++) begin
        hi_cnt[d][ch]    = 0;
        first_hi[d][ch]  = -1;
        rise_cnt[d][ch]  = 0;
        last_rise[d][ch] = -1;
        done_cnt[d][ch]  = 0;
        last_done[d][ch] = -1;
      end
    end
  endtask

  // Advance one clock, sample 1 time unit after the edge and record activity
  task automatic tick_obs();
    @(posedge gdma_clk);
    #1;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("busy_eq_rst.d%0d.c%0d", d, cyc), int'(busy[d]), int'(h2[d]));
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (h2[d][ch]) begin
          hi_cnt[d][ch]++;
          if (!prv[d][ch]) begin
            rise_cnt[d][ch]++;
            last_rise[d][ch] = cyc;
            if (first_hi[d][ch] < 0) first_hi[d][ch] = cyc;
          end
        end
        if (done[d][ch]) begin
          done_cnt[d][ch]++;
          last_done[d][ch] = cyc;
        end
      end
      prv[d] = h2[d];
    end
  endtask

  task automatic chk_ch(input string tag, input int d, input int ch, input int e_hi,
                        input int e_first, input int e_rise, input int e_lrise,
                        input int e_done, input int e_ldone);
    string p;
    p = $sformatf("%s.d%0d.ch%0d", tag, d, ch);
    check({p, ".high_cycles"}, hi_cnt[d][ch], e_hi);
    check({p, ".first_high"}, first_hi[d][ch], e_first);
    check({p, ".rises"}, rise_cnt[d][ch], e_rise);
    check({p, ".last_rise"}, last_rise[d][ch], e_lrise);
    check({p, ".done_count"}, done_cnt[d][ch], e_done);
    check({p, ".last_done"}, last_done[d][ch], e_ldone);
  endtask

  // Single request on one channel with a given config length; both instances agree
  task automatic run_len(input int ch, input int len, input int ncyc);
    cfg_pulse_len = CNT_W'(len);
    clear_obs();
    host_rst_flag[ch] = 1'b1;
    repeat (ncyc) tick_obs();
    for (int d = 0; d < 2; d++)
      chk_ch($sformatf("len%0d", len), d, ch, len, 3, 1, 3, 1, 3 + len);
    host_rst_flag[ch] = 1'b0;
    repeat (5) tick_obs();
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    gdma_rst      = 1'b1;
    host_rst_flag = '0;
    cfg_pulse_len = '0;
    clr_drop      = '0;
    clear_obs();

    // Reset state
    repeat (3) @(posedge gdma_clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset.h2gdma_rst.d%0d", d), int'(h2[d]), 0);
      check($sformatf("reset.rst_busy.d%0d", d), int'(busy[d]), 0);
      check($sformatf("reset.rst_done.d%0d", d), int'(done[d]), 0);
      check($sformatf("reset.req_drop.d%0d", d), int'(drop[d]), 0);
    end
    gdma_rst = 1'b0;
    repeat (4) tick_obs();

    // Default single pulse on channel 1: high cycles 3..12, done sampled at 13
    clear_obs();
    host_rst_flag[1] = 1'b1;
    repeat (20) tick_obs();
    for (int d = 0; d < 2; d++) begin
      chk_ch("single", d, 1, 10, 3, 1, 3, 1, 13);
      for (int ch = 0; ch < NUM_CH; ch++)
        if (ch != 1) chk_ch("single_quiet", d, ch, 0, -1, 0, -1, 0, -1);
    end
    host_rst_flag[1] = 1'b0;
    repeat (5) tick_obs();

    // Runtime lengths
    run_len(0, 3, 10);
    run_len(2, 1, 8);
    run_len(3, 255, 265);
    cfg_pulse_len = '0;

    // Second edge detected in pulse cycle 4: dropped (inst 0) / extended to 14 (inst 1)
    clear_obs();
    host_rst_flag[0] = 1'b1;
    tick_obs();
    host_rst_flag[0] = 1'b0;
    repeat (3) tick_obs();
    host_rst_flag[0] = 1'b1;
    repeat (20) tick_obs();
    chk_ch("drop", 0, 0, 10, 3, 1, 3, 1, 13);
    chk_ch("retrig", 1, 0, 14, 3, 1, 3, 1, 17);
    check("drop.req_drop.d0", int'(drop[0][0]), 1);
    check("retrig.req_drop.d1", int'(drop[1][0]), 0);
    host_rst_flag[0] = 1'b0;
    repeat (5) tick_obs();
    check("drop_sticky.d0", int'(drop[0][0]), 1);

    // Clear alone
    clr_drop[0] = 1'b1;
    tick_obs();
    clr_drop[0] = 1'b0;
    check("clr_alone.d0", int'(drop[0][0]), 0);

    // Clear in the same cycle as a new drop: set wins (drop registers at cycle 7)
    clear_obs();
    host_rst_flag[0] = 1'b1;
    tick_obs();
    host_rst_flag[0] = 1'b0;
    repeat (3) tick_obs();
    host_rst_flag[0] = 1'b1;
    repeat (2) tick_obs();
    check("pre_drop.d0", int'(drop[0][0]), 0);
    clr_drop[0] = 1'b1;
    tick_obs();
    clr_drop[0] = 1'b0;
    check("set_beats_clr.d0", int'(drop[0][0]), 1);
    check("set_beats_clr.d1", int'(drop[1][0]), 0);
    repeat (15) tick_obs();
    host_rst_flag[0] = 1'b0;
    repeat (5) tick_obs();
    clr_drop[0] = 1'b1;
    tick_obs();
    clr_drop[0] = 1'b0;
    check("clr_alone2.d0", int'(drop[0][0]), 0);

    // Reset at pulse cycle 5 with the request held high through reset
    clear_obs();
    host_rst_flag[2] = 1'b1;
    repeat (7) tick_obs();
    gdma_rst = 1'b1;
    tick_obs();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_mid.h2gdma_rst.d%0d", d), int'(h2[d][2]), 0);
      check($sformatf("rst_mid.rst_done.d%0d", d), int'(done[d][2]), 0);
    end
    tick_obs();
    gdma_rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_mid.high_before.d%0d", d), hi_cnt[d][2], 5);
      check($sformatf("rst_mid.no_done.d%0d", d), done_cnt[d][2], 0);
    end
    clear_obs();
    repeat (20) tick_obs();
    for (int d = 0; d < 2; d++) chk_ch("post_rst", d, 2, 10, 3, 1, 3, 1, 13);
    host_rst_flag[2] = 1'b0;
    repeat (5) tick_obs();

    // All channels together; channel 0 re-requests so its edge lands right after the pulse ends
    clear_obs();
    host_rst_flag = '1;
    repeat (8) tick_obs();
    host_rst_flag[0] = 1'b0;
    repeat (3) tick_obs();
    host_rst_flag[0] = 1'b1;
    repeat (19) tick_obs();
    for (int d = 0; d < 2; d++) begin
      chk_ch("b2b", d, 0, 20, 3, 2, 14, 2, 24);
      for (int ch = 1; ch < NUM_CH; ch++) chk_ch("all_ch", d, ch, 10, 3, 1, 3, 1, 13);
    end
    host_rst_flag = '0;
    repeat (5) tick_obs();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
